mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control sequencer that drives the `Datapath` control/operand ports (register file, ALU, data memory) from a 32-bit MIPS instruction.
- Accepts one instruction via a valid/ready handshake, decodes it, then steps the datapath through DECODE/EXEC/MEM/WB states.
- Replaces hand-sequenced control stimulus. Sits between the instruction source and `Datapath`.

Parameters:
- RST_STATE_IDLE, 1, reserved; must be 1 (reset always returns the FSM to IDLE).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_instr_valid  in  1  instruction present on i_instr.
- i_instr  in  32  MIPS instruction word.
- i_zero  in  1  ALU zero flag from datapath (used by beq).
- o_instr_ready  out  1  ready to accept an instruction.
- o_first5bits  out  5  rs = instr[25:21].
- o_second5bits  out  5  rt = instr[20:16].
- o_immediate  out  16  instr[15:0]; datapath uses [15:11] as rd when regDst=1.
- o_regDst  out  1  1 = write dest rd, 0 = rt.
- o_ReadWriteRF  out  1  1 = RF write enable.
- o_RFSource  out  1  0 = internal result, 1 = external write data; always 0 here.
- o_AluSource  out  1  1 = immediate operand, 0 = RFout2.
- o_AluControl  out  3  000 AND, 001 OR, 101 ADD, 110 SUB, 111 SLT.
- o_DMSource  out  1  0 = DM address from ALU; always 0.
- o_DMValue  out  1  0 = DM write data from RFout2; always 0.
- o_WriteEnDataMemory  out  1  DM write strobe.
- o_ReadEnDataMemory  out  1  DM read strobe.
- o_MemToReg  out  1  1 = WB from ALU, 0 = WB from memory.
- o_branch_taken  out  1  one-cycle pulse: beq condition true.
- o_done  out  1  one-cycle pulse: instruction retired.
- o_illegal  out  1  one-cycle pulse: unsupported opcode/funct.
- o_retired_cnt  out  32  retired-instruction count (optional feature).

Behaviour:
- Clock is i_clk, single domain. i_rst is synchronous and active-high.
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0, except o_instr_ready = 1 in the first cycle after i_rst deasserts.
  - Reset mid-instruction aborts it: no o_done, strobes drop the next cycle.
- States:
  - IDLE: o_instr_ready = 1. If i_instr_valid = 1, latch i_instr and go to DECODE.
  - DECODE: field outputs registered, o_regDst set.
    - Legal R-type, addi, lw, sw, beq → EXEC.
    - Anything else → IDLE with o_illegal = 1.
  - EXEC: o_AluSource/o_AluControl valid.
    - R-type/addi → WB; lw/sw → MEM.
    - beq: o_AluControl = SUB, sample i_zero. o_branch_taken = i_zero. o_done = 1. → IDLE.
  - MEM:
    - lw: o_ReadEnDataMemory = 1 → WB.
    - sw: o_WriteEnDataMemory = 1, o_done = 1 → IDLE.
  - WB: o_ReadWriteRF = 1, o_done = 1 → IDLE.
    - o_MemToReg = 1 for R-type/addi, 0 for lw.
- Latency from accept edge to o_done:
  - beq 2 cycles; R-type, addi, sw 3; lw 4; illegal 1 (o_illegal).
- Supported opcodes:
  - opcode 0x00 (R-type) with funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct is illegal.
  - 0x08 addi: ADD, AluSource = 1, regDst = 0.
  - 0x23 lw, 0x2B sw: ADD, AluSource = 1.
  - 0x04 beq: SUB, AluSource = 0.
- Strobes (ReadWriteRF, DM read/write, done, illegal, branch_taken) are high for exactly one cycle per instruction.
- Field outputs and o_regDst/o_AluSource/o_AluControl/o_MemToReg hold from DECODE until the next accept.
- o_instr_ready is low in DECODE/EXEC/MEM/WB. i_instr_valid in those states is ignored; the instruction waits.
- Back-to-back: the next instruction is accepted in the IDLE cycle right after o_done.
- All outputs are registered.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined:
  - o_retired_cnt increments by 1 on every o_done cycle. o_illegal cycles do not count.
  - Cleared by i_rst; wraps from 0xFFFFFFFF to 0.
- Undefined: o_retired_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Reset held 3 cycles mid-lw (after EXEC) → no o_done, no DM read strobe; o_instr_ready = 1 the cycle after release; all strobes 0.
- add $1,$2,$3 (0x00430820) →
  - DECODE: first = 2, second = 3, immediate = 0x0820, regDst = 1.
  - EXEC: AluControl = 101, AluSource = 0.
  - WB: ReadWriteRF = 1, MemToReg = 1, o_done.
  - Total 3 cycles after accept.
- lw $5,8($2) (0x8C450008) →
  - AluSource = 1, regDst = 0.
  - MEM: ReadEn = 1.
  - WB: MemToReg = 0, ReadWriteRF = 1; o_done at cycle 4.
- sw $5,4($2) (0xAC450004) → WriteEnDataMemory = 1 for one cycle with o_done at cycle 3; ReadWriteRF never asserted.
- beq (0x10430003), i_zero = 1 then repeated with i_zero = 0 → AluControl = 110; o_branch_taken = 1 / 0 with o_done at cycle 2.
- Illegal 0xFC000000, then funct 0x3F R-type → o_illegal pulse at cycle 1, no RF/DM strobes. With CTRL_RETIRE_CNT_EN defined, after the five legal instructions above, o_retired_cnt = 5.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control sequencer for the MIPS Datapath.
// Accepts one instruction, then steps IDLE -> DECODE -> EXEC [-> MEM] [-> WB].
// Every output is a flop; the output logic computes each value for the state
// being entered, so an output is always aligned with the state it belongs to.
// Optional feature macro: CTRL_RETIRE_CNT_EN (retired-instruction counter).
//
// Handshake: an instruction transfers on a rising edge where o_instr_ready
// and i_instr_valid are both 1. o_instr_ready is high only in IDLE; while it
// is low, i_instr_valid is ignored and the source must keep the word waiting.
module mips_multicycle_ctrl #(
  parameter int RST_STATE_IDLE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  output logic        o_instr_ready,
  output logic [4:0]  o_first5bits,
  output logic [4:0]  o_second5bits,
  output logic [15:0] o_immediate,
  output logic        o_regDst,
  output logic        o_ReadWriteRF,
  output logic        o_RFSource,
  output logic        o_AluSource,
  output logic [2:0]  o_AluControl,
  output logic        o_DMSource,
  output logic        o_DMValue,
  output logic        o_WriteEnDataMemory,
  output logic        o_ReadEnDataMemory,
  output logic        o_MemToReg,
  output logic        o_branch_taken,
  output logic        o_done,
  output logic        o_illegal,
  output logic [31:0] o_retired_cnt,
  output logic [2:0]  o_dbg_state
);

  if (RST_STATE_IDLE != 1) begin : g_param_check
    $error("RST_STATE_IDLE must be 1");
  end

  typedef enum logic [2:0] {S_IDLE = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                            S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [1:0] {K_ALU = 2'd0, K_LW = 2'd1, K_SW = 2'd2,
                            K_BEQ = 2'd3} kind_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      r_state, w_next_state;
  kind_t       r_kind, w_dec_kind;
  logic        r_legal, w_dec_legal;
  logic [2:0]  w_dec_alu_ctrl;
  logic        w_dec_alu_src, w_dec_reg_dst, w_dec_mem_to_reg;
  logic        w_accept;
  logic        w_ready_n, w_illegal_n, w_rf_we_n, w_rd_n, w_wr_n;
  logic        w_beq_exec, w_taken_n, w_done_n;

  logic        r_ready, r_rf_we, r_rd, r_wr, r_taken, r_done, r_illegal;
  logic [4:0]  r_rs, r_rt;
  logic [15:0] r_imm;
  logic        r_reg_dst, r_alu_src, r_mem_to_reg;
  logic [2:0]  r_alu_ctrl;

  assign w_accept = (r_state == S_IDLE) && r_ready && i_instr_valid;

  // Decode the incoming word so its controls can be registered at accept.
  always_comb begin
    w_dec_legal      = 1'b0;
    w_dec_kind       = K_ALU;
    w_dec_alu_ctrl   = 3'b000;
    w_dec_alu_src    = 1'b0;
    w_dec_reg_dst    = 1'b0;
    w_dec_mem_to_reg = 1'b0;
    case (i_instr[31:26])
      6'h00: begin
        w_dec_legal      = 1'b1;
        w_dec_reg_dst    = 1'b1;
        w_dec_mem_to_reg = 1'b1;
        case (i_instr[5:0])
          6'h20:   w_dec_alu_ctrl = ALU_ADD;
          6'h22:   w_dec_alu_ctrl = ALU_SUB;
          6'h24:   w_dec_alu_ctrl = ALU_AND;
          6'h25:   w_dec_alu_ctrl = ALU_OR;
          6'h2A:   w_dec_alu_ctrl = ALU_SLT;
          default: begin
            w_dec_legal      = 1'b0;
            w_dec_reg_dst    = 1'b0;
            w_dec_mem_to_reg = 1'b0;
          end
        endcase
      end
      6'h08: begin
        w_dec_legal      = 1'b1;
        w_dec_alu_ctrl   = ALU_ADD;
        w_dec_alu_src    = 1'b1;
        w_dec_mem_to_reg = 1'b1;
      end
      6'h23: begin
        w_dec_legal    = 1'b1;
        w_dec_kind     = K_LW;
        w_dec_alu_ctrl = ALU_ADD;
        w_dec_alu_src  = 1'b1;
      end
      6'h2B: begin
        w_dec_legal    = 1'b1;
        w_dec_kind     = K_SW;
        w_dec_alu_ctrl = ALU_ADD;
        w_dec_alu_src  = 1'b1;
      end
      6'h04: begin
        w_dec_legal    = 1'b1;
        w_dec_kind     = K_BEQ;
        w_dec_alu_ctrl = ALU_SUB;
      end
      default: w_dec_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Instruction class latched at accept; steers the sequence after DECODE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kind  <= K_ALU;
      r_legal <= 1'b0;
    end else if (w_accept) begin
      r_kind  <= w_dec_kind;
      r_legal <= w_dec_legal;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_DECODE;
      S_DECODE: w_next_state = r_legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        case (r_kind)
          K_ALU:   w_next_state = S_WB;
          K_BEQ:   w_next_state = S_IDLE;
          default: w_next_state = S_MEM;
        endcase
      end
      S_MEM:    w_next_state = (r_kind == K_LW) ? S_WB : S_IDLE;
      S_WB:     w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output logic: values for the state being entered on the next edge.
  // i_zero is sampled on the DECODE->EXEC edge; the SUB control is already
  // driven during DECODE, so the datapath zero flag is settled by then.
  always_comb begin
    w_ready_n   = (w_next_state == S_IDLE);
    w_illegal_n = w_accept && !w_dec_legal;
    w_rf_we_n   = (w_next_state == S_WB);
    w_rd_n      = (w_next_state == S_MEM) && (r_kind == K_LW);
    w_wr_n      = (w_next_state == S_MEM) && (r_kind == K_SW);
    w_beq_exec  = (w_next_state == S_EXEC) && (r_kind == K_BEQ);
    w_taken_n   = w_beq_exec && i_zero;
    w_done_n    = w_beq_exec || w_wr_n || w_rf_we_n;
  end

  // Output registers; fields and controls hold from accept to next accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_taken      <= 1'b0;
      r_done       <= 1'b0;
      r_illegal    <= 1'b0;
      r_rs         <= 5'd0;
      r_rt         <= 5'd0;
      r_imm        <= 16'd0;
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_alu_ctrl   <= 3'b000;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_ready   <= w_ready_n;
      r_rf_we   <= w_rf_we_n;
      r_rd      <= w_rd_n;
      r_wr      <= w_wr_n;
      r_taken   <= w_taken_n;
      r_done    <= w_done_n;
      r_illegal <= w_illegal_n;
      if (w_accept) begin
        r_rs         <= i_instr[25:21];
        r_rt         <= i_instr[20:16];
        r_imm        <= i_instr[15:0];
        r_reg_dst    <= w_dec_reg_dst;
        r_alu_src    <= w_dec_alu_src;
        r_alu_ctrl   <= w_dec_alu_ctrl;
        r_mem_to_reg <= w_dec_mem_to_reg;
      end
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] r_retired_cnt;
  // Retired count steps together with o_done; wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_retired_cnt <= 32'd0;
    else if (w_done_n) r_retired_cnt <= r_retired_cnt + 32'd1;
  end
  assign o_retired_cnt = r_retired_cnt;
`else
  assign o_retired_cnt = 32'd0;
`endif

  assign o_instr_ready       = r_ready;
  assign o_first5bits        = r_rs;
  assign o_second5bits       = r_rt;
  assign o_immediate         = r_imm;
  assign o_regDst            = r_reg_dst;
  assign o_ReadWriteRF       = r_rf_we;
  assign o_RFSource          = 1'b0;
  assign o_AluSource         = r_alu_src;
  assign o_AluControl        = r_alu_ctrl;
  assign o_DMSource          = 1'b0;
  assign o_DMValue           = 1'b0;
  assign o_WriteEnDataMemory = r_wr;
  assign o_ReadEnDataMemory  = r_rd;
  assign o_MemToReg          = r_mem_to_reg;
  assign o_branch_taken      = r_taken;
  assign o_done              = r_done;
  assign o_illegal           = r_illegal;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench for mips_multicycle_ctrl.
// The driver pushes the expected retirement of each issued instruction; the
// monitor pops and compares whenever o_done or o_illegal is presented.
module tb_mips_multicycle_ctrl;

`ifdef CTRL_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_rst, i_instr_valid, i_zero;
  logic [31:0] i_instr;
  logic        o_instr_ready, o_regDst, o_ReadWriteRF, o_RFSource, o_AluSource;
  logic [4:0]  o_first5bits, o_second5bits;
  logic [15:0] o_immediate;
  logic [2:0]  o_AluControl, o_dbg_state;
  logic        o_DMSource, o_DMValue, o_WriteEnDataMemory, o_ReadEnDataMemory;
  logic        o_MemToReg, o_branch_taken, o_done, o_illegal;
  logic [31:0] o_retired_cnt;

  mips_multicycle_ctrl #(.RST_STATE_IDLE(1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_instr_valid(i_instr_valid), .i_instr(i_instr),
    .i_zero(i_zero), .o_instr_ready(o_instr_ready), .o_first5bits(o_first5bits),
    .o_second5bits(o_second5bits), .o_immediate(o_immediate), .o_regDst(o_regDst),
    .o_ReadWriteRF(o_ReadWriteRF), .o_RFSource(o_RFSource), .o_AluSource(o_AluSource),
    .o_AluControl(o_AluControl), .o_DMSource(o_DMSource), .o_DMValue(o_DMValue),
    .o_WriteEnDataMemory(o_WriteEnDataMemory), .o_ReadEnDataMemory(o_ReadEnDataMemory),
    .o_MemToReg(o_MemToReg), .o_branch_taken(o_branch_taken), .o_done(o_done),
    .o_illegal(o_illegal), .o_retired_cnt(o_retired_cnt), .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        illegal;
    logic        taken;
    logic [2:0]  lat;
    logic [1:0]  n_rf;
    logic [1:0]  n_rd;
    logic [1:0]  n_wr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        reg_dst;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic        m2r;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int           acc_q[$];

  // Expected retirement summary of one instruction, from the ISA rules:
  // class gives latency and strobe counts, opcode/funct give the ALU op.
  function automatic exp_t model(input logic [31:0] ins, input logic z);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '0;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.imm = ins[15:0];
    e.illegal = 1'b1;
    e.lat = 3'd1;
    if (op == 6'h00) begin
      e.illegal = 1'b0;
      case (fn)
        6'h20: e.alu_ctl = 3'b101;
        6'h22: e.alu_ctl = 3'b110;
        6'h24: e.alu_ctl = 3'b000;
        6'h25: e.alu_ctl = 3'b001;
        6'h2A: e.alu_ctl = 3'b111;
        default: e.illegal = 1'b1;
      endcase
      if (!e.illegal) begin
        e.lat = 3'd3; e.n_rf = 2'd1; e.reg_dst = 1'b1; e.m2r = 1'b1;
      end
    end else if (op == 6'h08) begin
      e.illegal = 1'b0; e.lat = 3'd3; e.n_rf = 2'd1; e.alu_ctl = 3'b101;
      e.alu_src = 1'b1; e.m2r = 1'b1;
    end else if (op == 6'h23) begin
      e.illegal = 1'b0; e.lat = 3'd4; e.n_rf = 2'd1; e.n_rd = 2'd1;
      e.alu_ctl = 3'b101; e.alu_src = 1'b1;
    end else if (op == 6'h2B) begin
      e.illegal = 1'b0; e.lat = 3'd3; e.n_wr = 2'd1;
      e.alu_ctl = 3'b101; e.alu_src = 1'b1;
    end else if (op == 6'h04) begin
      e.illegal = 1'b0; e.lat = 3'd2; e.alu_ctl = 3'b110; e.taken = z;
    end
    return e;
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // ---------------- monitor ----------------
  int rd_total = 0;
  int done_total = 0;
  int n_rf = 0, n_rd = 0, n_wr = 0, n_tk = 0;
  int exp_ret = 0;
  bit ready_chk = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   a;
    int   lat;
    if (o_ReadEnDataMemory) rd_total++;
    if (o_done) done_total++;
    if (i_rst) begin
      n_rf = 0; n_rd = 0; n_wr = 0; n_tk = 0;
      ready_chk = 1'b0;
      exp_ret = 0;
    end else begin
      if (o_ReadWriteRF) n_rf++;
      if (o_ReadEnDataMemory) n_rd++;
      if (o_WriteEnDataMemory) n_wr++;
      if (o_branch_taken) n_tk++;
      if (ready_chk) begin
        check("ready_after_retire", o_instr_ready, 1);
        ready_chk = 1'b0;
      end
      if (o_instr_ready)
        check("idle_quiet", {o_ReadWriteRF, o_ReadEnDataMemory, o_WriteEnDataMemory,
                             o_branch_taken, o_done, o_illegal}, 0);
      if (o_done || o_illegal) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", {o_done, o_illegal}, 0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          a = acc_q.pop_front();
          lat = cyc - a + 1;
          check("latency", lat, e.lat);
          check("illegal_flag", o_illegal, e.illegal);
          check("done_flag", o_done, !e.illegal);
          check("rf_strobes", n_rf, e.n_rf);
          check("dm_rd_strobes", n_rd, e.n_rd);
          check("dm_wr_strobes", n_wr, e.n_wr);
          check("branch_taken", n_tk, e.taken);
          if (!e.illegal) begin
            exp_ret++;
            check("fields", {o_first5bits, o_second5bits, o_immediate},
                  {e.rs, e.rt, e.imm});
            check("regDst", o_regDst, e.reg_dst);
            check("AluSource", o_AluSource, e.alu_src);
            check("AluControl", o_AluControl, e.alu_ctl);
            check("MemToReg", o_MemToReg, e.m2r);
            check("fixed_sources", {o_RFSource, o_DMSource, o_DMValue}, 0);
            check("retired_cnt", o_retired_cnt, CNT_EN ? exp_ret : 0);
          end
        end
        n_rf = 0; n_rd = 0; n_wr = 0; n_tk = 0;
        ready_chk = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] ins, input logic z, input bit hold);
    int t;
    t = 0;
    @(negedge clk);
    while (!(o_instr_ready && exp_q.size() == 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("issue_timeout", t, 0);
      return;
    end
    i_instr = ins;
    i_zero = z;
    i_instr_valid = 1'b1;
    exp_q.push_back(model(ins, z));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    // Optionally keep valid high through DECODE: it must be ignored there.
    if (hold && !model(ins, z).illegal) @(negedge clk);
    i_instr_valid = 1'b0;
    i_instr = $urandom();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("retire_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_instr_ready, 0);
    check({tag, "_strobes"}, {o_ReadWriteRF, o_ReadEnDataMemory, o_WriteEnDataMemory,
                              o_branch_taken, o_done, o_illegal}, 0);
    check({tag, "_ctrl"}, {o_regDst, o_AluSource, o_AluControl, o_MemToReg,
                           o_RFSource, o_DMSource, o_DMValue}, 0);
    check({tag, "_fields"}, {o_first5bits, o_second5bits, o_immediate}, 0);
    check({tag, "_cnt"}, o_retired_cnt, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [5:0] funct_tab [5];
  initial begin : main
    int before_rd;
    int before_done;
    logic [31:0] ins;
    int sel;
    funct_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    i_rst = 1'b1;
    i_instr_valid = 1'b0;
    i_instr = 32'd0;
    i_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", o_instr_ready, 1);

    // Reset during EXEC of a lw: aborted, no read strobe and no done.
    before_rd = rd_total;
    before_done = done_total;
    issue(32'h8C450008, 1'b0, 1'b0);   // returns at the DECODE cycle
    @(negedge clk);                    // EXEC cycle
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    exp_q.delete();
    acc_q.delete();
    i_rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", o_instr_ready, 1);
    check("abort_no_dm_read", rd_total, before_rd);
    check("abort_no_done", done_total, before_done);

    // Directed instructions.
    issue(32'h00430820, 1'b0, 1'b0); wait_idle();   // add $1,$2,$3
    issue(32'h8C450008, 1'b0, 1'b1); wait_idle();   // lw $5,8($2)
    issue(32'hAC450004, 1'b1, 1'b0); wait_idle();   // sw $5,4($2)
    issue(32'h10430003, 1'b1, 1'b0); wait_idle();   // beq, zero = 1
    issue(32'h10430003, 1'b0, 1'b1); wait_idle();   // beq, zero = 0
    issue(32'hFC000000, 1'b0, 1'b0); wait_idle();   // illegal opcode
    issue(32'h0043083F, 1'b0, 1'b0); wait_idle();   // illegal funct
    @(negedge clk);
    check("retired_after_directed", o_retired_cnt, CNT_EN ? 5 : 0);

    // Randomized mix of legal and illegal words.
    for (int k = 0; k < 150; k++) begin
      ins = $urandom();
      sel = $urandom_range(0, 6);
      case (sel)
        0: begin ins[31:26] = 6'h00; ins[5:0] = funct_tab[$urandom_range(0, 4)]; end
        1: ins[31:26] = 6'h08;
        2: ins[31:26] = 6'h23;
        3: ins[31:26] = 6'h2B;
        4: ins[31:26] = 6'h04;
        5: ins[31:26] = 6'h00;
        default: ;
      endcase
      issue(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end

    repeat (2) @(negedge clk);
    check("retired_final", o_retired_cnt, CNT_EN ? exp_ret : 0);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
